hazard_ctrl_v2: RTL and testbench

- Parametrised successor to the core's single-cycle branch-stall hazard unit.
- Sits beside the IF/ID register.
- Detects RAW hazards of the ID-stage instruction against EX and MEM producers, covering load-use as well as branch-in-ID operands.
- Issues multi-cycle stalls from a counter FSM, and generates redirect flushes that stay aligned with the synchronous IMEM for FLUSH_CYCLES cycles.

---
 rtl/hazard_ctrl_v2_pkg.sv | 33 +++
 rtl/hazard_ctrl_v2_if.sv | 38 +++
 rtl/hazard_ctrl_v2_src_match.sv | 13 +
 rtl/hazard_ctrl_v2.sv | 182 ++++++++++++++++++
 tb/tb_hazard_ctrl_v2.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_v2_pkg.sv
// hazard_ctrl_v2_pkg: FSM state, hazard cause and RV32I opcode encodings
// shared by the hazard unit, its match cells and its users.
package hazard_ctrl_v2_pkg;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_LOAD_USE = 2'd1,
        CAUSE_BRANCH   = 2'd2,
        CAUSE_FLUSH    = 2'd3
    } cause_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op == OPC_LUI || op == OPC_AUIPC || op == OPC_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return op == OPC_BRANCH || op == OPC_STORE || op == OPC_OP;
    endfunction

endpackage

// File: rtl/hazard_ctrl_v2_if.sv
// hazard_ctrl_v2_if: ID/producer inputs and pipeline control outputs
// of the hazard unit; the pipeline is master, the hazard unit is slave.
interface hazard_ctrl_v2_if #(
    parameter int REG_ADDR_W = 5
);
    logic                  id_valid;
    logic [6:0]            id_opcode;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  ex_reg_we;
    logic                  mem_reg_we;
    logic                  ex_is_load;
    logic                  mem_is_load;
    logic                  ctrl_pc_src;
    logic                  ctrl_pc_en;
    logic                  ctrl_imem_en;
    logic                  ctrl_id_reg_flush;
    logic                  ctrl_zero_sel;
    logic [1:0]            hazard_cause;

    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2,
        output ex_rd, mem_rd, ex_reg_we, mem_reg_we,
        output ex_is_load, mem_is_load, ctrl_pc_src,
        input  ctrl_pc_en, ctrl_imem_en, ctrl_id_reg_flush,
        input  ctrl_zero_sel, hazard_cause
    );

    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2,
        input  ex_rd, mem_rd, ex_reg_we, mem_reg_we,
        input  ex_is_load, mem_is_load, ctrl_pc_src,
        output ctrl_pc_en, ctrl_imem_en, ctrl_id_reg_flush,
        output ctrl_zero_sel, hazard_cause
    );
endinterface

// File: rtl/hazard_ctrl_v2_src_match.sv
// hazard_src_match: one source register checked against one producer;
// x0 never matches since its writes are discarded.
module hazard_src_match #(
    parameter int W = 5
) (
    input  logic [W-1:0] rs,
    input  logic         used,
    input  logic [W-1:0] rd,
    input  logic         we,
    output logic         match
);
    assign match = used && we && (rs == rd) && (rd != '0);
endmodule

// File: rtl/hazard_ctrl_v2.sv
// hazard_ctrl_v2: RAW stall/flush control beside the IF/ID register.
// Define HAZARD_PERF_CNT_EN to add the 32-bit stall/flush cycle counters.
module hazard_ctrl_v2
    import hazard_ctrl_v2_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int LOAD_LAT     = 1,
    parameter int BRANCH_IN_ID = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 2
) (
    input logic             clk,
    input logic             rst,
    hazard_ctrl_v2_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]     perf_stall_cycles,
    output logic [31:0]     perf_flush_cycles
`endif
);

    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO    = CNT_W'(2);
    localparam logic [CNT_W-1:0] LL     = CNT_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0] LL_M1  = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] LL_P1  = CNT_W'(LOAD_LAT + 1);
    localparam logic [CNT_W-1:0] FL_RLD = CNT_W'(FLUSH_CYCLES - 1);

    logic use1, use2;
    logic m1_ex, m2_ex, m1_mem, m2_mem;
    logic ex_hit, mem_hit, is_br;
    logic br_win, ld_win;
    logic [CNT_W-1:0] ld_req, br_req, req;
    logic [1:0] det_cause;

    logic [1:0] state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0] cause_q, cause_d;
    logic stall_now, pc_en, imem_en, flush_q;

    assign use1 = uses_rs1(hz.id_opcode);
    assign use2 = uses_rs2(hz.id_opcode);

    hazard_src_match #(.W(REG_ADDR_W)) u_m1_ex (
        .rs(hz.id_rs1), .used(use1), .rd(hz.ex_rd),
        .we(hz.ex_reg_we), .match(m1_ex)
    );
    hazard_src_match #(.W(REG_ADDR_W)) u_m2_ex (
        .rs(hz.id_rs2), .used(use2), .rd(hz.ex_rd),
        .we(hz.ex_reg_we), .match(m2_ex)
    );
    hazard_src_match #(.W(REG_ADDR_W)) u_m1_mem (
        .rs(hz.id_rs1), .used(use1), .rd(hz.mem_rd),
        .we(hz.mem_reg_we), .match(m1_mem)
    );
    hazard_src_match #(.W(REG_ADDR_W)) u_m2_mem (
        .rs(hz.id_rs2), .used(use2), .rd(hz.mem_rd),
        .we(hz.mem_reg_we), .match(m2_mem)
    );

    // Largest applicable rule wins; the branch rule wins a tie.
    always_comb begin
        ex_hit  = m1_ex || m2_ex;
        mem_hit = m1_mem || m2_mem;
        is_br   = (BRANCH_IN_ID != 0) && (hz.id_opcode == OPC_BRANCH);
        ld_req  = '0;
        if (mem_hit && hz.mem_is_load)
            ld_req = LL_M1;
        if (ex_hit && hz.ex_is_load)
            ld_req = LL;
        br_req = '0;
        if (is_br && ex_hit)
            br_req = hz.ex_is_load ? LL_P1 : ONE;
        br_win = (br_req != '0) && (br_req >= ld_req);
        ld_win = (ld_req != '0) && !br_win;
        req       = '0;
        det_cause = CAUSE_NONE;
        unique case (1'b1)
            br_win: begin
                req       = br_req;
                det_cause = CAUSE_BRANCH;
            end
            ld_win: begin
                req       = ld_req;
                det_cause = CAUSE_LOAD_USE;
            end
            default: ;
        endcase
    end

    // The detect cycle is the first stall cycle, so STALL covers req-1 more.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cause_d   = cause_q;
        stall_now = 1'b0;
        if (hz.ctrl_pc_src) begin
            state_d = ST_FLUSH;
            cnt_d   = FL_RLD;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (hz.id_valid && req != '0) begin
                        stall_now = 1'b1;
                        cause_d   = det_cause;
                        if (req > ONE) begin
                            state_d = ST_STALL;
                            cnt_d   = req - TWO;
                        end
                    end
                end
                ST_STALL: begin
                    stall_now = 1'b1;
                    if (cnt_q == '0)
                        state_d = ST_RUN;
                    else
                        cnt_d = cnt_q - ONE;
                end
                ST_FLUSH: begin
                    if (cnt_q == '0)
                        state_d = ST_RUN;
                    else
                        cnt_d = cnt_q - ONE;
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    assign pc_en   = rst && !stall_now;
    assign imem_en = !rst || pc_en;

    always_comb begin
        hz.hazard_cause = CAUSE_NONE;
        if (!rst)
            hz.hazard_cause = CAUSE_NONE;
        else if (hz.ctrl_pc_src || state_q == ST_FLUSH)
            hz.hazard_cause = CAUSE_FLUSH;
        else if (state_q == ST_STALL)
            hz.hazard_cause = cause_q;
        else if (stall_now)
            hz.hazard_cause = det_cause;
    end

    assign hz.ctrl_pc_en        = pc_en;
    assign hz.ctrl_imem_en      = imem_en;
    assign hz.ctrl_zero_sel     = !pc_en || (hz.id_opcode == 7'd0);
    assign hz.ctrl_id_reg_flush = flush_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    // Registered so the flush lines up with the synchronous IMEM output.
    always_ff @(posedge clk) begin
        flush_q <= !rst || (imem_en && hz.ctrl_pc_src) ||
                   (state_q == ST_FLUSH && cnt_q != '0);
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_stall_cycles <= '0;
            perf_flush_cycles <= '0;
        end else begin
            if (!pc_en && perf_stall_cycles != '1)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (state_q == ST_FLUSH && perf_flush_cycles != '1)
                perf_flush_cycles <= perf_flush_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl_v2.sv
// tb_hazard_ctrl_v2: two instances (LOAD_LAT/FLUSH_CYCLES 1/1 and 2/2)
// checked each cycle against a cycle-count model, plus literal pins.
module tb_hazard_ctrl_v2;
    import hazard_ctrl_v2_pkg::*;

    logic clk = 1'b0;
    logic rst;
    bit   armed = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    hazard_ctrl_v2_if #(.REG_ADDR_W(5)) a_if ();
    hazard_ctrl_v2_if #(.REG_ADDR_W(5)) b_if ();

    always_comb begin
        b_if.id_valid    = a_if.id_valid;
        b_if.id_opcode   = a_if.id_opcode;
        b_if.id_rs1      = a_if.id_rs1;
        b_if.id_rs2      = a_if.id_rs2;
        b_if.ex_rd       = a_if.ex_rd;
        b_if.mem_rd      = a_if.mem_rd;
        b_if.ex_reg_we   = a_if.ex_reg_we;
        b_if.mem_reg_we  = a_if.mem_reg_we;
        b_if.ex_is_load  = a_if.ex_is_load;
        b_if.mem_is_load = a_if.mem_is_load;
        b_if.ctrl_pc_src = a_if.ctrl_pc_src;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] a_ps, a_pf, b_ps, b_pf;
`endif

    hazard_ctrl_v2 #(
        .REG_ADDR_W(5), .LOAD_LAT(1), .BRANCH_IN_ID(1),
        .FLUSH_CYCLES(1), .CNT_W(2)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .hz(a_if.slave)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_stall_cycles(a_ps),
        .perf_flush_cycles(a_pf)
`endif
    );

    hazard_ctrl_v2 #(
        .REG_ADDR_W(5), .LOAD_LAT(2), .BRANCH_IN_ID(1),
        .FLUSH_CYCLES(2), .CNT_W(2)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .hz(b_if.slave)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_stall_cycles(b_ps),
        .perf_flush_cycles(b_pf)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- model ----------------
    int ll_p[2] = '{1, 2};
    int fc_p[2] = '{1, 2};
    int owed[2] = '{0, 0};
    int fleft[2] = '{0, 0};
    int held[2] = '{0, 0};
    bit fq[2] = '{1'b1, 1'b1};
    longint ps[2] = '{0, 0};
    longint pf[2] = '{0, 0};

    function automatic bit hit(input logic [4:0] rs, input logic [4:0] rd,
                               input logic we);
        return we && rs != 5'd0 && rs == rd;
    endfunction

    function automatic void need_of(input int ll, output int nd, output int nc);
        logic [6:0] op;
        bit u1, u2, exh, memh;
        int rv[3];
        int rc[3];
        op   = a_if.id_opcode;
        u1   = !(op inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
        u2   = op inside {OPC_BRANCH, OPC_STORE, OPC_OP};
        exh  = (u1 && hit(a_if.id_rs1, a_if.ex_rd, a_if.ex_reg_we)) ||
               (u2 && hit(a_if.id_rs2, a_if.ex_rd, a_if.ex_reg_we));
        memh = (u1 && hit(a_if.id_rs1, a_if.mem_rd, a_if.mem_reg_we)) ||
               (u2 && hit(a_if.id_rs2, a_if.mem_rd, a_if.mem_reg_we));
        rv = '{0, 0, 0};
        rc = '{1, 1, 2};
        if (exh && a_if.ex_is_load) rv[0] = ll;
        if (memh && a_if.mem_is_load) rv[1] = ll - 1;
        if (op == OPC_BRANCH && exh) rv[2] = a_if.ex_is_load ? ll + 1 : 1;
        nd = 0;
        nc = 0;
        for (int k = 2; k >= 0; k--)
            if (rv[k] > nd) begin
                nd = rv[k];
                nc = rc[k];
            end
    endfunction

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                int nd, nc, e_cause;
                bit e_pc, e_imem, e_zero, fq_n, in_fl;
                logic [5:0] d;
                string t;
                t = (i == 0) ? "A" : "B";
                d = (i == 0) ?
                    {a_if.ctrl_pc_en, a_if.ctrl_imem_en,
                     a_if.ctrl_id_reg_flush, a_if.ctrl_zero_sel,
                     a_if.hazard_cause} :
                    {b_if.ctrl_pc_en, b_if.ctrl_imem_en,
                     b_if.ctrl_id_reg_flush, b_if.ctrl_zero_sel,
                     b_if.hazard_cause};
                need_of(ll_p[i], nd, nc);
                in_fl = 1'b0;
                fq_n  = 1'b0;
                if (!rst) begin
                    e_pc = 0; e_cause = 0;
                    owed[i] = 0; fleft[i] = 0; fq_n = 1;
                end else if (a_if.ctrl_pc_src) begin
                    e_pc = 1; e_cause = 3;
                    owed[i] = 0; fleft[i] = fc_p[i]; fq_n = 1;
                end else if (owed[i] > 0) begin
                    e_pc = 0; e_cause = held[i];
                    owed[i]--;
                end else if (fleft[i] > 0) begin
                    e_pc = 1; e_cause = 3; in_fl = 1;
                    fq_n = fleft[i] > 1;
                    fleft[i]--;
                end else if (a_if.id_valid && nd > 0) begin
                    e_pc = 0; e_cause = nc;
                    held[i] = nc; owed[i] = nd - 1;
                end else begin
                    e_pc = 1; e_cause = 0;
                end
                e_imem = !rst || e_pc;
                e_zero = !e_pc || a_if.id_opcode == 7'd0;
                chk({t, " pc_en"}, 32'(d[5]), 32'(e_pc));
                chk({t, " imem_en"}, 32'(d[4]), 32'(e_imem));
                chk({t, " id_reg_flush"}, 32'(d[3]), 32'(fq[i]));
                chk({t, " zero_sel"}, 32'(d[2]), 32'(e_zero));
                chk({t, " cause"}, 32'(d[1:0]), 32'(e_cause));
`ifdef HAZARD_PERF_CNT_EN
                chk({t, " perf_stall"}, (i == 0) ? a_ps : b_ps, 32'(ps[i]));
                chk({t, " perf_flush"}, (i == 0) ? a_pf : b_pf, 32'(pf[i]));
`endif
                fq[i] = fq_n;
                if (!rst) begin
                    ps[i] = 0;
                    pf[i] = 0;
                end else begin
                    if (!e_pc) ps[i]++;
                    if (in_fl) pf[i]++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic id(input logic [6:0] op, input logic [4:0] r1,
                      input logic [4:0] r2);
        a_if.id_valid  = 1'b1;
        a_if.id_opcode = op;
        a_if.id_rs1    = r1;
        a_if.id_rs2    = r2;
    endtask

    task automatic prod(input logic [4:0] erd, input logic ewe,
                        input logic eld, input logic [4:0] mrd,
                        input logic mwe, input logic mld);
        a_if.ex_rd       = erd;
        a_if.ex_reg_we   = ewe;
        a_if.ex_is_load  = eld;
        a_if.mem_rd      = mrd;
        a_if.mem_reg_we  = mwe;
        a_if.mem_is_load = mld;
    endtask

    task automatic idle();
        id(OPC_OP_IMM, 5'd1, 5'd2);
        prod(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        a_if.ctrl_pc_src = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        @(posedge clk);
        #1 armed = 1'b1;
        mid();
        chk("rst pc_en", 32'(a_if.ctrl_pc_en), 0);
        chk("rst imem_en", 32'(a_if.ctrl_imem_en), 1);
        chk("rst zero_sel", 32'(a_if.ctrl_zero_sel), 1);
        chk("rst cause", 32'(a_if.hazard_cause), 0);
        chk("rst flush", 32'(a_if.ctrl_id_reg_flush), 1);
        tick();
        rst = 1'b1;
        mid();
        chk("release pc_en", 32'(a_if.ctrl_pc_en), 1);
        tick();

        // load-use: EX load x5, ADD rs1=x5
        id(OPC_OP, 5'd5, 5'd6);
        prod(5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        mid();
        chk("lu A pc_en", 32'(a_if.ctrl_pc_en), 0);
        chk("lu A zero_sel", 32'(a_if.ctrl_zero_sel), 1);
        chk("lu A cause", 32'(a_if.hazard_cause), 1);
        tick();
        prod(5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
        mid();
        chk("lu A resume", 32'(a_if.ctrl_pc_en), 1);
        chk("lu B held", 32'(b_if.ctrl_pc_en), 0);
        chk("lu B cause", 32'(b_if.hazard_cause), 1);
        tick();
        idle();
        mid();
        chk("lu B resume", 32'(b_if.ctrl_pc_en), 1);
        tick();

        // branch in ID, ALU producer in EX
        id(OPC_BRANCH, 5'd3, 5'd7);
        prod(5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        mid();
        chk("br A pc_en", 32'(a_if.ctrl_pc_en), 0);
        chk("br A cause", 32'(a_if.hazard_cause), 2);
        tick();
        idle();
        mid();
        chk("br A resume", 32'(a_if.ctrl_pc_en), 1);
        tick();

        // branch in ID, load producer in EX: B stalls 3 cycles
        id(OPC_BRANCH, 5'd3, 5'd7);
        prod(5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        mid();
        chk("brld B c1", 32'(b_if.ctrl_pc_en), 0);
        chk("brld B cause", 32'(b_if.hazard_cause), 2);
        tick();
        prod(5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1);
        mid();
        chk("brld A c2", 32'(a_if.ctrl_pc_en), 0);
        tick();
        prod(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        mid();
        chk("brld A c3", 32'(a_if.ctrl_pc_en), 1);
        chk("brld B c3", 32'(b_if.ctrl_pc_en), 0);
        chk("brld B c3 cause", 32'(b_if.hazard_cause), 2);
        tick();
        idle();
        mid();
        chk("brld B c4", 32'(b_if.ctrl_pc_en), 1);
        tick();

        // x0, no-write, unused sources, NOP, invalid ID: no stall
        id(OPC_OP, 5'd0, 5'd9);
        prod(5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        mid();
        chk("x0 pc_en", 32'(a_if.ctrl_pc_en), 1);
        tick();
        id(OPC_OP, 5'd5, 5'd6);
        prod(5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        mid();
        chk("nowe pc_en", 32'(a_if.ctrl_pc_en), 1);
        tick();
        id(OPC_LUI, 5'd5, 5'd5);
        prod(5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        mid();
        chk("lui pc_en", 32'(a_if.ctrl_pc_en), 1);
        tick();
        id(OPC_OP_IMM, 5'd1, 5'd5);
        mid();
        chk("addi rs2 pc_en", 32'(a_if.ctrl_pc_en), 1);
        tick();
        id(OPC_OP, 5'd5, 5'd5);
        a_if.id_valid = 1'b0;
        mid();
        chk("invalid pc_en", 32'(a_if.ctrl_pc_en), 1);
        tick();
        idle();
        id(7'd0, 5'd0, 5'd0);
        mid();
        chk("nop zero_sel", 32'(a_if.ctrl_zero_sel), 1);
        chk("nop pc_en", 32'(a_if.ctrl_pc_en), 1);
        tick();

        // redirect in the 2nd stall cycle
        id(OPC_BRANCH, 5'd3, 5'd7);
        prod(5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        tick();
        prod(5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1);
        a_if.ctrl_pc_src = 1'b1;
        mid();
        chk("rd B pc_en", 32'(b_if.ctrl_pc_en), 1);
        chk("rd B cause", 32'(b_if.hazard_cause), 3);
        tick();
        idle();
        mid();
        chk("rd A flush1", 32'(a_if.ctrl_id_reg_flush), 1);
        chk("rd B flush1", 32'(b_if.ctrl_id_reg_flush), 1);
        chk("rd B pc_en2", 32'(b_if.ctrl_pc_en), 1);
        tick();
        mid();
        chk("rd A flush2", 32'(a_if.ctrl_id_reg_flush), 0);
        chk("rd B flush2", 32'(b_if.ctrl_id_reg_flush), 1);
        chk("rd A cause2", 32'(a_if.hazard_cause), 0);
        tick();
        mid();
        chk("rd B flush3", 32'(b_if.ctrl_id_reg_flush), 0);
        tick();

        // back-to-back redirects reload the flush count
        a_if.ctrl_pc_src = 1'b1;
        tick();
        tick();
        a_if.ctrl_pc_src = 1'b0;
        mid();
        chk("b2b B cause c3", 32'(b_if.hazard_cause), 3);
        tick();
        mid();
        chk("b2b B cause c4", 32'(b_if.hazard_cause), 3);
        chk("b2b A cause c4", 32'(a_if.hazard_cause), 0);
        tick();
        mid();
        chk("b2b B cause c5", 32'(b_if.hazard_cause), 0);
        tick();

        // reset in mid-stall
        id(OPC_BRANCH, 5'd3, 5'd7);
        prod(5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        tick();
        prod(5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1);
        rst = 1'b0;
        mid();
        chk("mrst B pc_en", 32'(b_if.ctrl_pc_en), 0);
        chk("mrst B imem_en", 32'(b_if.ctrl_imem_en), 1);
        chk("mrst B cause", 32'(b_if.hazard_cause), 0);
        tick();
        rst = 1'b1;
        idle();
        mid();
        chk("mrst B flush", 32'(b_if.ctrl_id_reg_flush), 1);
        chk("mrst B resume", 32'(b_if.ctrl_pc_en), 1);
        tick();
        mid();
        chk("mrst B flush off", 32'(b_if.ctrl_id_reg_flush), 0);
        tick();

        // counter run: reset, 3 load-use, 2 redirects
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        for (int n = 0; n < 3; n++) begin
            id(OPC_OP, 5'd5, 5'd6);
            prod(5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
            tick();
            idle();
            tick();
            tick();
        end
        for (int n = 0; n < 2; n++) begin
            a_if.ctrl_pc_src = 1'b1;
            tick();
            a_if.ctrl_pc_src = 1'b0;
            tick();
            tick();
        end
        mid();
`ifdef HAZARD_PERF_CNT_EN
        chk("perf A stall", a_ps, 32'd3);
        chk("perf A flush", a_pf, 32'd2);
`endif
        chk("end A pc_en", 32'(a_if.ctrl_pc_en), 1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
